// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard unit: operand-forward
// selects, FSM states and register index width.
package hazard_pkg;

  localparam int REG_AW = 5;

  typedef logic [REG_AW-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_MW = 2'd1,
    FWD_LD = 2'd2
  } fwd_sel_e;

  typedef enum logic {
    RUN      = 1'b0,
    LD_STALL = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard unit
// (slave): DE-stage instruction descriptors in, forward/stall/flush controls out.
interface hazard_if;
  import hazard_pkg::*;

  reg_idx_t    de_rs1;
  reg_idx_t    de_rs2;
  logic        de_rs1_used;
  logic        de_rs2_used;
  reg_idx_t    de_rd;
  logic        de_reg_wr;
  logic        de_is_load;
  logic        de_valid;
  logic        br_taken;

  logic [1:0]  fwd_sel_a;
  logic [1:0]  fwd_sel_b;
  logic        stall_f;
  logic        stall_de;
  logic        flush_de;
  logic        flush_f;
  logic [31:0] stall_cnt;

  modport master (
    output de_rs1, de_rs2, de_rs1_used, de_rs2_used, de_rd,
           de_reg_wr, de_is_load, de_valid, br_taken,
    input  fwd_sel_a, fwd_sel_b, stall_f, stall_de, flush_de, flush_f, stall_cnt
  );

  modport slave (
    input  de_rs1, de_rs2, de_rs1_used, de_rs2_used, de_rd,
           de_reg_wr, de_is_load, de_valid, br_taken,
    output fwd_sel_a, fwd_sel_b, stall_f, stall_de, flush_de, flush_f, stall_cnt
  );

endinterface

// File: rtl/fwd_compare.sv
// Per-operand comparator: picks the forwarding source for one DE source
// register and flags a load-use hazard on it.
module fwd_compare
  import hazard_pkg::*;
(
  input  reg_idx_t rs,
  input  logic     rs_used,
  input  logic     de_valid,
  input  reg_idx_t mw_rd,
  input  logic     mw_we,
  input  logic     mw_ld,
  input  reg_idx_t ld_rd,
  input  logic     ld_we,
  output fwd_sel_e sel,
  output logic     hazard
);

  logic live;

  // NOTE: every output gets a default before the if-chain so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    sel    = FWD_RF;
    live   = rs_used && (rs != '0);
    if (live && mw_we && !mw_ld && (mw_rd == rs)) begin
      sel = FWD_MW;
    end else if (live && ld_we && (ld_rd == rs)) begin
      sel = FWD_LD;
    end
    hazard = de_valid && live && mw_we && mw_ld && (mw_rd == rs);
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard unit: tracks the MW and load-data stages, forwards operands, and
// inserts a one-cycle bubble on load-use hazards.
module hazard_unit
  import hazard_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  hazard_if.slave  hz
);

  reg_idx_t  mw_rd;
  logic      mw_we;
  logic      mw_ld;
  reg_idx_t  ld_rd;
  logic      ld_we;

  hz_state_e state;
  hz_state_e state_nxt;
  logic      stall;
  logic      flush_f;
  logic      haz_a;
  logic      haz_b;
  fwd_sel_e  sel_a;
  fwd_sel_e  sel_b;
  logic [31:0] stall_cnt_q;

  fwd_compare u_fwd_a (
    .rs       (hz.de_rs1),
    .rs_used  (hz.de_rs1_used),
    .de_valid (hz.de_valid),
    .mw_rd    (mw_rd),
    .mw_we    (mw_we),
    .mw_ld    (mw_ld),
    .ld_rd    (ld_rd),
    .ld_we    (ld_we),
    .sel      (sel_a),
    .hazard   (haz_a)
  );

  fwd_compare u_fwd_b (
    .rs       (hz.de_rs2),
    .rs_used  (hz.de_rs2_used),
    .de_valid (hz.de_valid),
    .mw_rd    (mw_rd),
    .mw_we    (mw_we),
    .mw_ld    (mw_ld),
    .ld_rd    (ld_rd),
    .ld_we    (ld_we),
    .sel      (sel_b),
    .hazard   (haz_b)
  );

  // In LD_STALL the MW slot already holds the bubble, so no second stall.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    unique case (state)
      RUN: begin
        if (haz_a || haz_b) begin
          stall     = 1'b1;
          state_nxt = LD_STALL;
        end
      end
      LD_STALL: state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
    flush_f = hz.br_taken && hz.de_valid && !stall;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      mw_rd       <= '0;
      mw_we       <= 1'b0;
      mw_ld       <= 1'b0;
      ld_rd       <= '0;
      ld_we       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state <= state_nxt;
      if (stall) begin
        mw_rd <= '0;
        mw_we <= 1'b0;
        mw_ld <= 1'b0;
      end else begin
        mw_rd <= hz.de_rd;
        mw_we <= hz.de_reg_wr && hz.de_valid;
        mw_ld <= hz.de_is_load && hz.de_valid;
      end
      ld_rd <= mw_rd;
      ld_we <= mw_we && mw_ld;
      if (stall) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  // Outputs are forced quiet for the whole reset cycle, not just after it.
  assign hz.fwd_sel_a = rst ? 2'(FWD_RF) : 2'(sel_a);
  assign hz.fwd_sel_b = rst ? 2'(FWD_RF) : 2'(sel_b);
  assign hz.stall_f   = stall && !rst;
  assign hz.stall_de  = stall && !rst;
  assign hz.flush_de  = stall && !rst;
  assign hz.flush_f   = flush_f && !rst;
  assign hz.stall_cnt = rst ? 32'd0 : stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed instruction sequences push
// expected controls; a negedge monitor pops and compares them.
module tb_hazard_unit;

  logic clk;
  logic rst;
  hazard_if hz ();

  hazard_unit dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  typedef struct {
    int          vec;
    logic [1:0]  sa;
    logic [1:0]  sb;
    logic        st;
    logic        ff;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   vec_no = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int vec,
                       input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s vec=%0d got=%0h want=%0h", name, vec, act, want);
    end
  endtask

  // Apply one DE-stage vector for one cycle and record its expected controls.
  task automatic step(input logic r,
                      input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2,
                      input logic [4:0] rd, input logic we, input logic ld,
                      input logic v, input logic br,
                      input logic [1:0] sa, input logic [1:0] sb,
                      input logic st, input logic ff, input logic [31:0] cnt);
    exp_t x;
    @(posedge clk);
    #1;
    rst            = r;
    hz.de_rs1      = rs1;
    hz.de_rs1_used = u1;
    hz.de_rs2      = rs2;
    hz.de_rs2_used = u2;
    hz.de_rd       = rd;
    hz.de_reg_wr   = we;
    hz.de_is_load  = ld;
    hz.de_valid    = v;
    hz.br_taken    = br;
    x.vec = vec_no;
    x.sa  = sa;
    x.sb  = sb;
    x.st  = st;
    x.ff  = ff;
    x.cnt = cnt;
    exp_q.push_back(x);
    vec_no++;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("fwd_sel_a", e.vec, 32'(hz.fwd_sel_a), 32'(e.sa));
      check("fwd_sel_b", e.vec, 32'(hz.fwd_sel_b), 32'(e.sb));
      check("stall_f",   e.vec, 32'(hz.stall_f),   32'(e.st));
      check("stall_de",  e.vec, 32'(hz.stall_de),  32'(e.st));
      check("flush_de",  e.vec, 32'(hz.flush_de),  32'(e.st));
      check("flush_f",   e.vec, 32'(hz.flush_f),   32'(e.ff));
      check("stall_cnt", e.vec, hz.stall_cnt,      e.cnt);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    //     r rs1 u rs2 u rd we ld v br  sa sb st ff cnt
    // Reset with busy inputs: everything must read zero.
    step(1,  5,1,  5,1,  5,1,1, 1,1,  0,0,0,0,0);
    step(1,  5,1,  5,1,  5,1,1, 1,1,  0,0,0,0,0);
    // add x5 ; sub x6,x5,x1 -> MW forward
    step(0,  1,1,  2,1,  5,1,0, 1,0,  0,0,0,0,0);
    step(0,  5,1,  1,1,  6,1,0, 1,0,  1,0,0,0,0);
    // lw x7 ; add x8,x7,x7 -> one stall, then load-slot forward
    step(0,  1,1,  0,0,  7,1,1, 1,0,  0,0,0,0,0);
    step(0,  7,1,  7,1,  8,1,0, 1,0,  0,0,1,0,0);
    step(0,  7,1,  7,1,  8,1,0, 1,0,  2,2,0,0,1);
    // lw x7 ; nop ; add x8,x7,x0 -> no stall, A from load slot
    step(0,  2,1,  0,0,  7,1,1, 1,0,  0,0,0,0,1);
    step(0,  0,1,  0,0,  0,1,0, 1,0,  0,0,0,0,1);
    step(0,  7,1,  0,1,  8,1,0, 1,0,  2,0,0,0,1);
    // addi x0 ; use x0 -> never forwarded
    step(0,  1,1,  0,0,  0,1,0, 1,0,  0,0,0,0,1);
    step(0,  0,1,  0,1, 10,1,0, 1,0,  0,0,0,0,1);
    // lw x0 ; use x0 -> never stalls
    step(0,  1,1,  0,0,  0,1,1, 1,0,  0,0,0,0,1);
    step(0,  0,1,  0,1, 11,1,0, 1,0,  0,0,0,0,1);
    // lw x3 ; beq x3,x3 taken -> stall wins, then flush_f
    step(0,  1,1,  0,0,  3,1,1, 1,0,  0,0,0,0,1);
    step(0,  3,1,  3,1,  0,0,0, 1,1,  0,0,1,0,1);
    step(0,  3,1,  3,1,  0,0,0, 1,1,  2,2,0,1,2);
    // Taken branch on a bubble does not flush
    step(0,  3,1,  0,0,  0,0,0, 0,1,  0,0,0,0,2);
    // lw x4 ; invalid DE reading x4 -> no stall
    step(0,  1,1,  0,0,  4,1,1, 1,0,  0,0,0,0,2);
    step(0,  4,1,  4,1,  9,1,0, 0,0,  0,0,0,0,2);
    // lw x12 ; add x13,x12,x1 stalls ; reset during LD_STALL
    step(0,  1,1,  0,0, 12,1,1, 1,0,  0,0,0,0,2);
    step(0, 12,1,  1,1, 13,1,0, 1,0,  0,0,1,0,2);
    step(1, 12,1,  1,1, 13,1,0, 1,0,  0,0,0,0,0);
    step(0, 12,1,  1,1, 13,1,0, 1,0,  0,0,0,0,0);
    step(0, 13,1,  1,1, 15,1,0, 1,0,  1,0,0,0,0);
    // lw x14 ; addi x14 ; use x14 -> MW beats load slot
    step(0,  1,1,  0,0, 14,1,1, 1,0,  0,0,0,0,0);
    step(0,  1,1,  0,0, 14,1,0, 1,0,  0,0,0,0,0);
    step(0, 14,1, 14,1, 16,1,0, 1,0,  1,1,0,0,0);
    // Unused operand is never forwarded
    step(0, 16,0, 16,1, 17,1,0, 1,0,  0,1,0,0,0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
